// File: rtl/vga_timing_pkg.sv
// Purpose : shared timing constants and helpers for the VGA sync generator.
//           640x480@60 Hz defaults, coordinate width, axis total / sync window helpers.
// Ports   : none (package).
package vga_timing_pkg;

   localparam int unsigned COORD_W     = 10;
   localparam int unsigned FRAME_CNT_W = 8;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned sync_first(input int unsigned active, input int unsigned fp);
      return active + fp;
   endfunction

   function automatic int unsigned sync_last(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync);
      return active + fp + sync - 1;
   endfunction

   localparam int unsigned H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned H_SYNC_START = sync_first(H_ACTIVE, H_FP);
   localparam int unsigned H_SYNC_END   = sync_last(H_ACTIVE, H_FP, H_SYNC);
   localparam int unsigned V_SYNC_START = sync_first(V_ACTIVE, V_FP);
   localparam int unsigned V_SYNC_END   = sync_last(V_ACTIVE, V_FP, V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose : one timing axis (horizontal or vertical): wrapping counter plus
//           registered active-low sync decoded from the next count.
// Ports   : clk, rst_n, cnt_en          - clock, async reset, advance enable
//           total, sync_start, sync_end - axis length and inclusive sync window
//           active_len                  - visible length of the axis
//           count                       - registered position
//           wrap_c                      - advancing from total-1 to 0 this cycle
//           sync                        - registered sync, low inside the window
//           active_c                    - next position is in the visible region
module vga_axis_counter
   import vga_timing_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cnt_en,
   input  logic [COORD_W-1:0] total,
   input  logic [COORD_W-1:0] sync_start,
   input  logic [COORD_W-1:0] sync_end,
   input  logic [COORD_W-1:0] active_len,
   output logic [COORD_W-1:0] count,
   output logic               wrap_c,
   output logic               sync,
   output logic               active_c
);

   logic               last_c;
   logic [COORD_W-1:0] count_nxt_c;
   logic               sync_nxt_c;

   // Next count; outputs are decoded from it so they align with the count register.
   always_comb begin
      last_c      = (count == (total - COORD_W'(1)));
      wrap_c      = cnt_en && last_c;
      count_nxt_c = count;
      if (cnt_en) begin
         count_nxt_c = last_c ? '0 : count + COORD_W'(1);
      end
      sync_nxt_c = !((count_nxt_c >= sync_start) && (count_nxt_c <= sync_end));
      active_c   = (count_nxt_c < active_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sync  <= 1'b1;
      end else begin
         count <= count_nxt_c;
         sync  <= sync_nxt_c;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose : free-running VGA timing generator (default 640x480@60) with
//           synchronous frame tick, frame counter and motion tick.
// Config  : VGA_SYNC_MOVE_TICK_EN - when defined, move_tick fires on every
//           2^MOVE_DIV_LOG2-th frame; otherwise move_tick is frame_tick.
// Ports   : clk, rst_n, en          - pixel clock, async reset, pixel enable
//           hsync, vsync            - active-low syncs, aligned with hpos/vpos
//           display_on              - visible region flag
//           hpos, vpos              - pixel coordinates
//           frame_tick, frame_cnt   - one-cycle pulse at (0, V_ACTIVE), frame count
//           move_tick               - divided frame pulse
module vga_sync_gen
   import vga_timing_pkg::COORD_W, vga_timing_pkg::FRAME_CNT_W;
#(
   parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP
`ifdef VGA_SYNC_MOVE_TICK_EN
   ,
   parameter int unsigned MOVE_DIV_LOG2 = 1
`endif
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   display_on,
   output logic [COORD_W-1:0]     hpos,
   output logic [COORD_W-1:0]     vpos,
   output logic                   frame_tick,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   move_tick
);

   localparam logic [COORD_W-1:0] H_TOTAL_C = COORD_W'(vga_timing_pkg::axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam logic [COORD_W-1:0] V_TOTAL_C = COORD_W'(vga_timing_pkg::axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam logic [COORD_W-1:0] H_SS_C    = COORD_W'(vga_timing_pkg::sync_first(H_ACTIVE, H_FP));
   localparam logic [COORD_W-1:0] H_SE_C    = COORD_W'(vga_timing_pkg::sync_last(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [COORD_W-1:0] V_SS_C    = COORD_W'(vga_timing_pkg::sync_first(V_ACTIVE, V_FP));
   localparam logic [COORD_W-1:0] V_SE_C    = COORD_W'(vga_timing_pkg::sync_last(V_ACTIVE, V_FP, V_SYNC));
   localparam logic [COORD_W-1:0] H_ACT_C   = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C   = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] V_LAST_ACT_C = COORD_W'(V_ACTIVE - 1);

   logic                   h_wrap_c;
   logic                   v_wrap_c;
   logic                   v_en_c;
   logic                   h_active_c;
   logic                   v_active_c;
   logic                   tick_c;
   logic [FRAME_CNT_W-1:0] frame_cnt_nxt_c;

   assign v_en_c = en && h_wrap_c;

   vga_axis_counter u_h_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_en     (en),
      .total      (H_TOTAL_C),
      .sync_start (H_SS_C),
      .sync_end   (H_SE_C),
      .active_len (H_ACT_C),
      .count      (hpos),
      .wrap_c     (h_wrap_c),
      .sync       (hsync),
      .active_c   (h_active_c)
   );

   vga_axis_counter u_v_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_en     (v_en_c),
      .total      (V_TOTAL_C),
      .sync_start (V_SS_C),
      .sync_end   (V_SE_C),
      .active_len (V_ACT_C),
      .count      (vpos),
      .wrap_c     (v_wrap_c),
      .sync       (vsync),
      .active_c   (v_active_c)
   );

   // Tick on the edge that moves the raster to (0, V_ACTIVE); en low suppresses it.
   always_comb begin
      tick_c          = en && h_wrap_c && (vpos == V_LAST_ACT_C);
      frame_cnt_nxt_c = frame_cnt + FRAME_CNT_W'(tick_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_on <= 1'b1;
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         display_on <= h_active_c && v_active_c;
         frame_tick <= tick_c;
         frame_cnt  <= frame_cnt_nxt_c;
      end
   end

`ifdef VGA_SYNC_MOVE_TICK_EN
   localparam logic [FRAME_CNT_W-1:0] MOVE_MASK = FRAME_CNT_W'((1 << MOVE_DIV_LOG2) - 1);

   // Divided tick keyed on the post-increment frame count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         move_tick <= 1'b0;
      end else begin
         move_tick <= tick_c && ((frame_cnt_nxt_c & MOVE_MASK) == '0);
      end
   end
`else
   assign move_tick = frame_tick;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose : self-checking bench for vga_sync_gen. A full-size instance covers
//           line timing; a reduced-geometry instance covers frame-level behaviour.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   localparam int unsigned S_HA = 12, S_HF = 2, S_HS = 3, S_HB = 3;
   localparam int unsigned S_VA = 6,  S_VF = 1, S_VS = 1, S_VB = 2;
   localparam int unsigned S_HT = S_HA + S_HF + S_HS + S_HB;   // 20
   localparam int unsigned S_VT = S_VA + S_VF + S_VS + S_VB;   // 10

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] h;
      logic [9:0] v;
      logic       ft;
      logic [7:0] fc;
      logic       mt;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;

   logic       d_hsync, d_vsync, d_de, d_ft, d_mt;
   logic [9:0] d_hpos, d_vpos;
   logic [7:0] d_fc;
   logic       s_hsync, s_vsync, s_de, s_ft, s_mt;
   logic [9:0] s_hpos, s_vpos;
   logic [7:0] s_fc;

   int n_checks = 0;
   int n_pass   = 0;

   obs_t sb[$];
   int unsigned m_h, m_v;
   logic [7:0]  m_fc;
   logic        m_ft;

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hsync(d_hsync), .vsync(d_vsync), .display_on(d_de),
      .hpos(d_hpos), .vpos(d_vpos),
      .frame_tick(d_ft), .frame_cnt(d_fc), .move_tick(d_mt)
   );

   vga_sync_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hsync(s_hsync), .vsync(s_vsync), .display_on(s_de),
      .hpos(s_hpos), .vpos(s_vpos),
      .frame_tick(s_ft), .frame_cnt(s_fc), .move_tick(s_mt)
   );

   // Expected small-instance outputs from the reference raster position.
   function automatic obs_t model_obs();
      obs_t o;
      o.hs = !((m_h >= S_HA + S_HF) && (m_h < S_HA + S_HF + S_HS));
      o.vs = !((m_v >= S_VA + S_VF) && (m_v < S_VA + S_VF + S_VS));
      o.de = (m_h < S_HA) && (m_v < S_VA);
      o.h  = 10'(m_h);
      o.v  = 10'(m_v);
      o.ft = m_ft;
      o.fc = m_fc;
`ifdef VGA_SYNC_MOVE_TICK_EN
      o.mt = m_ft && (m_fc[0] == 1'b0);
`else
      o.mt = m_ft;
`endif
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o = {s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ft, s_fc, s_mt};
      return o;
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_fc = 8'd0; m_ft = 1'b0;
   endtask

   task automatic model_step(input logic e);
      if (e) begin
         if (m_h == S_HT - 1) begin
            m_h = 0;
            m_v = (m_v == S_VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         m_ft = (m_h == 0) && (m_v == S_VA);
         if (m_ft) m_fc = m_fc + 8'd1;
      end else begin
         m_ft = 1'b0;
      end
   endtask

   // One clock with en = e; expected result queued, outputs settled on return.
   task automatic drive_cycle(input logic e);
      @(negedge clk);
      en = e;
      @(posedge clk);
      model_step(e);
      sb.push_back(model_obs());
      #1;
   endtask

   task automatic test_reset();
      obs_t got, exp, exp_d, got_d;
      rst_n = 1'b0; en = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      sb.push_back(model_obs());
      exp = sb.pop_front();
      got = dut_obs();
      n_checks++;
      if (got !== exp) $display("FAIL reset_small: got %h required %h", got, exp);
      else n_pass++;
      exp_d = '{hs: 1'b1, vs: 1'b1, de: 1'b1, h: 10'd0, v: 10'd0, ft: 1'b0, fc: 8'd0, mt: 1'b0};
      got_d = {d_hsync, d_vsync, d_de, d_hpos, d_vpos, d_ft, d_fc, d_mt};
      n_checks++;
      if (got_d !== exp_d) $display("FAIL reset_full: got %h required %h", got_d, exp_d);
      else n_pass++;
   endtask

   task automatic test_line();
      obs_t got, exp;
      int lo_cnt = 0, lo_first = -1, lo_last = -1, de_first = -1, bad = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= H_TOTAL; i++) begin
         drive_cycle(1'b1);
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) begin
            bad++;
            $display("FAIL line_small cyc %0d: got %h required %h", i, got, exp);
         end
         if (!d_hsync) begin
            lo_cnt++;
            if (lo_first < 0) lo_first = int'(d_hpos);
            lo_last = int'(d_hpos);
         end
         if (!d_de && de_first < 0) de_first = int'(d_hpos);
         if (i == H_TOTAL - 1) begin
            n_checks++;
            if (d_hpos !== 10'd799 || d_vpos !== 10'd0)
               $display("FAIL line_end: got (%0d,%0d) required (799,0)", d_hpos, d_vpos);
            else n_pass++;
         end
      end
      n_checks++;
      if (bad != 0) $display("FAIL line_small: %0d cycles differ, required 0", bad);
      else n_pass++;
      n_checks++;
      if (d_hpos !== 10'd0 || d_vpos !== 10'd1)
         $display("FAIL line_wrap: got (%0d,%0d) required (0,1)", d_hpos, d_vpos);
      else n_pass++;
      n_checks++;
      if (lo_cnt != 96 || lo_first != 656 || lo_last != 751)
         $display("FAIL hsync_window: got %0d cycles %0d..%0d required 96 cycles 656..751",
                  lo_cnt, lo_first, lo_last);
      else n_pass++;
      n_checks++;
      if (de_first != 640) $display("FAIL display_on_end: got %0d required 640", de_first);
      else n_pass++;
   endtask

   task automatic test_frame();
      obs_t got, exp;
      int ticks = 0, vs_lo = 0, bad = 0;
      for (int i = 0; i < int'(S_HT * S_VT); i++) begin
         drive_cycle(1'b1);
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) begin
            bad++;
            $display("FAIL frame cyc %0d: got %h required %h", i, got, exp);
         end
         if (s_ft) ticks++;
         if (!s_vsync) vs_lo++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL frame: %0d cycles differ, required 0", bad);
      else n_pass++;
      n_checks++;
      if (ticks != 1) $display("FAIL frame_ticks: got %0d required 1", ticks);
      else n_pass++;
      n_checks++;
      if (vs_lo != int'(S_VS * S_HT)) $display("FAIL vsync_width: got %0d required %0d", vs_lo, S_VS * S_HT);
      else n_pass++;
      n_checks++;
      if (s_fc !== 8'd5) $display("FAIL frame_cnt: got %0d required 5", s_fc);
      else n_pass++;
   endtask

   task automatic test_en_toggle();
      obs_t got, exp;
      int ticks = 0, bad = 0, wide = 0;
      logic prev_ft = 1'b0;
      for (int i = 0; i < int'(2 * S_HT * S_VT); i++) begin
         drive_cycle(1'((i + 1) % 2));
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) begin
            bad++;
            $display("FAIL en_toggle cyc %0d: got %h required %h", i, got, exp);
         end
         if (s_ft) ticks++;
         if (s_ft && prev_ft) wide++;
         prev_ft = s_ft;
      end
      n_checks++;
      if (bad != 0) $display("FAIL en_toggle: %0d cycles differ, required 0", bad);
      else n_pass++;
      n_checks++;
      if (ticks != 1 || wide != 0)
         $display("FAIL en_toggle_ticks: got %0d ticks %0d stretched, required 1 and 0", ticks, wide);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      obs_t got, exp;
      int bad = 0, n = 0, tick_at = -1;
      bit reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
         drive_cycle(1'b1);
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) bad++;
         if (m_h == 7 && m_v == 3) reached = 1;
      end
      n_checks++;
      if (!reached || bad != 0)
         $display("FAIL midframe_reach: reached %0d, %0d cycles differ, required 1 and 0", reached, bad);
      else n_pass++;
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      sb.push_back(model_obs());
      exp = sb.pop_front();
      got = dut_obs();
      n_checks++;
      if (got !== exp) $display("FAIL reset_async: got %h required %h", got, exp);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (dut_obs() !== exp) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL reset_hold: %0d cycles differ, required 0", bad);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      while (tick_at < 0 && n < 400) begin
         drive_cycle(1'b1);
         n++;
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) bad++;
         if (s_ft) tick_at = n;
      end
      n_checks++;
      if (tick_at != int'(S_VA * S_HT) || bad != 0)
         $display("FAIL first_tick_after_reset: got %0d (%0d diffs) required %0d", tick_at, bad, S_VA * S_HT);
      else n_pass++;
   endtask

   task automatic test_frame_wrap();
      obs_t got, exp;
      int ticks = 0, moves = 0, bad = 0, budget = 0;
      logic [7:0] fc_last = 8'hxx;
`ifdef VGA_SYNC_MOVE_TICK_EN
      int moves_req = 128;
`else
      int moves_req = 255;
`endif
      while (ticks < 255 && budget < 256 * int'(S_HT * S_VT)) begin
         drive_cycle(1'b1);
         budget++;
         exp = sb.pop_front();
         got = dut_obs();
         if (got !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL wrap_run cyc %0d: got %h required %h", budget, got, exp);
         end
         if (s_ft) begin
            ticks++;
            fc_last = s_fc;
         end
         if (s_mt) moves++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL wrap_run: %0d cycles differ, required 0", bad);
      else n_pass++;
      n_checks++;
      if (ticks != 255 || fc_last !== 8'd0)
         $display("FAIL frame_cnt_wrap: got %0d ticks cnt %0d required 255 ticks cnt 0", ticks, fc_last);
      else n_pass++;
      n_checks++;
      if (moves != moves_req) $display("FAIL move_ticks: got %0d required %0d", moves, moves_req);
      else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_line();
      test_frame();
      test_en_toggle();
      test_reset_midframe();
      test_frame_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
